one_hot_decade_counter: RTL
===========================

Name: one_hot_decade_counter

Overview:
- Synchronous decade counter; one-hot state register drives a 10-bit `hot` bus.
- Sits directly upstream of the one-digit 7-segment display stage; `hot` connects straight to that stage's `hot` input.
- Built-in prescaler turns the fast board clock into a visible count rate.
- `carry` output allows cascading digits: one digit's `carry` drives the next digit's `en`.

Parameters:
- DIV, 50000000, enabled clock cycles per count step; legal range 1..2^26-1; DIV=1 steps on every enabled cycle.
- CW, 26, prescaler counter width; must satisfy 2^CW > DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; prescaler advances only while high.
- up  input  1  direction: 1 = count up (0→9), 0 = count down (9→0).
- load  input  1  synchronous load strobe.
- load_val  input  4  digit to load, binary.
- hot  output  10  one-hot digit; bit n high means digit n; registered.
- carry  output  1  one-cycle wrap pulse; registered.

Behaviour:
- Reset: clk and reset are fixed as above (one clock; reset synchronous, active-high). At the edge with reset=1:
  - hot=10'b0000000001
  - carry=0
  - prescaler=0
- Reset overrides load and en.
- Priority per edge: reset > load > count > hold.
- Load (load=1):
  - load_val 0..9 → hot = 1<<load_val.
  - load_val 10..15 → hot=10'b0000000001.
  - Prescaler cleared to 0; carry=0 that cycle; en ignored.
- Prescaler:
  - While en=1 and no load: psc increments each edge.
  - When psc==DIV-1: psc←0 and a step occurs on that same edge.
  - While en=0: psc holds its value; hot holds; carry=0.
- Step latency:
  - First step occurs DIV enabled edges after reset/load.
  - New hot value is visible the cycle after that edge.
- Step up:
  - hot rotates left one bit (bit n → bit n+1).
  - From 10'b1000000000: hot←10'b0000000001 and carry=1 for exactly one cycle.
- Step down:
  - hot rotates right.
  - From 10'b0000000001: hot←10'b1000000000 and carry=1 for one cycle.
- carry timing: updates on the same edge as the wrapping hot update; 0 on all other cycles.
- `up` is sampled only on step edges. Changing it mid-prescale affects the next step only.
- Illegal state: if hot is not exactly one-hot (zero bits or multiple bits), the next non-reset edge forces hot←10'b0000000001 with carry=0. This takes precedence over stepping but not over load.
- Cascade: tens digit en = units carry, with tens DIV=1. Tens then steps exactly once per units wrap.
- No combinational path from any input to hot or carry.

Optional Feature:
- Macro: HOLD_AT_LIMIT_EN.
- Defined:
  - Counter saturates: up-step at digit 9 holds 9; down-step at digit 0 holds 0.
  - carry pulses once on the step edge that attempts to pass the limit; it stays 0 on further attempted steps while held.
  - Prescaler keeps running.
- Undefined:
  - Wrap-around behaviour as above (9→0 up, 0→9 down, carry on each wrap).

Test Plan:
- DIV=3, reset then en=1, up=1 for 30 cycles:
  - hot walks 0x001→0x002→… with one step every 3 cycles.
  - Wraps 0x200→0x001 with a single-cycle carry at cycle 30.
- DIV=1, load=1 load_val=4:
  - Next cycle hot=0x010, carry=0.
  - Then up=0: hot=0x008, 0x004, 0x002, 0x001, 0x200, with carry=1 only on the 0x001→0x200 step.
- DIV=1, load_val=12 → hot=0x001.
- DIV=5:
  - Drop en after 3 enabled cycles, hold low 10 cycles, re-raise → first step lands after 2 more enabled cycles (prescaler held).
  - Hold en high with load=1 continuously → hot frozen at the loaded value, no carry.
- reset asserted together with load=1, load_val=7 and an in-progress count at digit 9 → hot=0x001, carry=0, next step only after DIV enabled cycles.
- HOLD_AT_LIMIT_EN defined, DIV=1, load 8, up=1, en=1 for 4 cycles:
  - hot=0x100, 0x200, 0x200, 0x200.
  - carry=1 only on the first attempted step past 9.
- Without the macro, same stimulus:
  - hot=0x100, 0x200, 0x001, 0x002.
  - carry high only as hot becomes 0x001.

Source files
------------

// File: rtl/one_hot_decade_counter.sv
// One-hot decade counter with built-in prescaler and cascade carry.
// Define HOLD_AT_LIMIT_EN to saturate at 9/0 instead of wrapping.
module one_hot_decade_counter #(
    parameter int DIV = 50000000,
    parameter int CW  = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [9:0] hot,
    output logic       carry
);

    localparam logic [CW-1:0] PSC_LAST = CW'(DIV - 1);

    logic [9:0]    r_hot;
    logic          r_carry;
    logic [CW-1:0] r_psc;

    logic [9:0]    w_next_hot;
    logic          w_next_carry;
    logic [CW-1:0] w_next_psc;
    logic [9:0]    w_load_hot;
    logic          w_onehot;
    logic          w_step;

`ifdef HOLD_AT_LIMIT_EN
    logic r_held;
    logic w_next_held;
`endif

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_onehot   = (r_hot != 10'd0) && ((r_hot & (r_hot - 10'd1)) == 10'd0);
    assign w_step     = en && (r_psc == PSC_LAST);
    assign w_load_hot = (load_val <= 4'd9) ? (10'd1 << load_val) : 10'd1;

    always_comb begin
        w_next_hot   = r_hot;
        w_next_carry = 1'b0;
        w_next_psc   = r_psc;
`ifdef HOLD_AT_LIMIT_EN
        w_next_held  = r_held;
`endif
        if (load) begin
            w_next_hot  = w_load_hot;
            w_next_psc  = '0;
`ifdef HOLD_AT_LIMIT_EN
            w_next_held = 1'b0;
`endif
        end else begin
            if (en)
                w_next_psc = w_step ? '0 : r_psc + CW'(1);
            if (!w_onehot) begin
                w_next_hot  = 10'd1;
`ifdef HOLD_AT_LIMIT_EN
                w_next_held = 1'b0;
`endif
            end else if (w_step) begin
                if (up && r_hot[9]) begin
`ifdef HOLD_AT_LIMIT_EN
                    // Carry only on the first blocked attempt at the limit.
                    w_next_carry = ~r_held;
                    w_next_held  = 1'b1;
`else
                    w_next_hot   = 10'd1;
                    w_next_carry = 1'b1;
`endif
                end else if (!up && r_hot[0]) begin
`ifdef HOLD_AT_LIMIT_EN
                    w_next_carry = ~r_held;
                    w_next_held  = 1'b1;
`else
                    w_next_hot   = 10'h200;
                    w_next_carry = 1'b1;
`endif
                end else begin
                    w_next_hot = up ? {r_hot[8:0], 1'b0} : {1'b0, r_hot[9:1]};
`ifdef HOLD_AT_LIMIT_EN
                    w_next_held = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hot   <= 10'd1;
            r_carry <= 1'b0;
            r_psc   <= '0;
`ifdef HOLD_AT_LIMIT_EN
            r_held  <= 1'b0;
`endif
        end else begin
            r_hot   <= w_next_hot;
            r_carry <= w_next_carry;
            r_psc   <= w_next_psc;
`ifdef HOLD_AT_LIMIT_EN
            r_held  <= w_next_held;
`endif
        end
    end

    assign hot   = r_hot;
    assign carry = r_carry;

endmodule
